// File: rtl/c2_to_bcd_converter_if.sv
// Handshake and result bus of the binary-to-BCD converter.
// The master side requests conversions; the slave side (the converter)
// reports progress and presents the seven BCD digits.
interface c2_to_bcd_converter_if;
    logic        start;
    logic [22:0] value_C2;
    logic        busy;
    logic        done;
    logic [3:0]  d_1;
    logic [3:0]  d_2;
    logic [3:0]  d_3;
    logic [3:0]  d_4;
    logic [3:0]  d_5;
    logic [3:0]  d_6;
    logic [3:0]  d_7;

    modport master (
        output start, value_C2,
        input  busy, done, d_1, d_2, d_3, d_4, d_5, d_6, d_7
    );

    modport slave (
        input  start, value_C2,
        output busy, done, d_1, d_2, d_3, d_4, d_5, d_6, d_7
    );
endinterface

// File: rtl/c2_to_bcd_converter.sv
// Sequential double-dabble converter: 23-bit unsigned binary to 7 BCD digits.
// One input bit is consumed per clock, MSB first, so a conversion takes
// exactly 23 cycles; done pulses on the edge performing the last shift and
// the digit registers change only on that edge (or on reset).
module c2_to_bcd_converter (
    input  logic                        clk,
    input  logic                        rst,
    c2_to_bcd_converter_if.slave        bus
);
    localparam int DATA_W = 23;
    localparam int DIGITS = 7;
    localparam int BCD_W  = 4 * DIGITS;

    typedef enum logic {IDLE, CONV} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [DATA_W-1:0]      shift_reg;
    logic [DATA_W-1:0]      shift_next;
    logic [BCD_W-1:0]       scratch;
    logic [BCD_W-1:0]       scratch_next;
    logic [4:0]             count;
    logic [4:0]             count_next;
    logic [BCD_W-1:0]       digits;
    logic [BCD_W-1:0]       digits_next;
    logic                   busy;
    logic                   busy_next;
    logic                   done;
    logic                   done_next;

    logic [BCD_W-1:0]       adjusted;
    logic [BCD_W+DATA_W-1:0] shifted;

    // Add 3 to every nibble that is 5 or more, so the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            nib = s[4*i +: 4];
            r[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        return r;
    endfunction

    // One double-dabble step: adjust the scratch digits, then shift the
    // combined {scratch, shift register} left by one bit.
    always_comb begin
        adjusted = add3_all(scratch);
        shifted  = {adjusted, shift_reg} << 1;
    end

    // Next-state and datapath decode; every register holds unless changed.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        scratch_next = scratch;
        count_next   = count;
        digits_next  = digits;
        busy_next    = 1'b0;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    shift_next   = bus.value_C2;
                    scratch_next = '0;
                    count_next   = 5'(DATA_W);
                    busy_next    = 1'b1;
                    state_next   = CONV;
                end
            end
            CONV: begin
                scratch_next = shifted[BCD_W+DATA_W-1:DATA_W];
                shift_next   = shifted[DATA_W-1:0];
                count_next   = count - 5'd1;
                if (count == 5'd1) begin
                    // Last bit consumed: publish the finished digits.
                    digits_next = shifted[BCD_W+DATA_W-1:DATA_W];
                    done_next   = 1'b1;
                    state_next  = IDLE;
                end else begin
                    busy_next   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any conversion silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
            digits    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            scratch   <= scratch_next;
            count     <= count_next;
            digits    <= digits_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.d_1  = digits[3:0];
    assign bus.d_2  = digits[7:4];
    assign bus.d_3  = digits[11:8];
    assign bus.d_4  = digits[15:12];
    assign bus.d_5  = digits[19:16];
    assign bus.d_6  = digits[23:20];
    assign bus.d_7  = digits[27:24];
endmodule

// File: tb/tb_c2_to_bcd_converter.sv
// Self-checking bench for the binary-to-BCD converter. Expected digits are
// computed arithmetically from the value; expected timing is edge counting.
module tb_c2_to_bcd_converter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    c2_to_bcd_converter_if bus ();

    c2_to_bcd_converter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: k-th decimal digit of v (k = 1 is units).
    function automatic int ref_digit(input int v, input int k);
        int p;
        p = 1;
        for (int i = 1; i < k; i++) p = p * 10;
        return (v / p) % 10;
    endfunction

    function automatic int got_digit(input int k);
        case (k)
            1: return int'(bus.d_1);
            2: return int'(bus.d_2);
            3: return int'(bus.d_3);
            4: return int'(bus.d_4);
            5: return int'(bus.d_5);
            6: return int'(bus.d_6);
            default: return int'(bus.d_7);
        endcase
    endfunction

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge (edge N), then scramble value_C2.
    task automatic start_conv(input int v);
        bus.start    = 1'b1;
        bus.value_C2 = 23'(v);
        step();
        bus.start    = 1'b0;
        bus.value_C2 = 23'($urandom_range(8388607, 0));
    endtask

    // Wait for done, bounded; lat counts edges, busy_cnt counts busy-high samples.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            lat++;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.value_C2 = '0;
        step();
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (got_digit(k) !== 0) begin
                errors++;
                $display("FAIL reset_digit d_%0d got %0d required 0", k, got_digit(k));
            end
        end
        // Start coinciding with reset is ignored.
        bus.start = 1'b1;
        bus.value_C2 = 23'd77;
        step();
        bus.start = 1'b0;
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start busy=%b required 0", bus.busy);
        end
        step();
    endtask

    task automatic test_zero();
        int lat, bc;
        start_conv(0);
        wait_done(lat, bc);
        checks++;
        if (lat !== 23 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL zero_latency got %0d done=%b required 23 1", lat, bus.done);
        end
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (got_digit(k) !== 0) begin
                errors++;
                $display("FAIL zero_digit d_%0d got %0d required 0", k, got_digit(k));
            end
        end
        step();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_width done=%b required 0", bus.done);
        end
    endtask

    task automatic test_max();
        int lat, bc, b0;
        start_conv(8388607);
        b0 = (bus.busy === 1'b1) ? 1 : 0;
        wait_done(lat, bc);
        checks++;
        if (lat !== 23) begin
            errors++;
            $display("FAIL max_latency got %0d required 23", lat);
        end
        checks++;
        if (b0 + bc !== 23) begin
            errors++;
            $display("FAIL max_busy_cycles got %0d required 23", b0 + bc);
        end
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (got_digit(k) !== ref_digit(8388607, k)) begin
                errors++;
                $display("FAIL max_digit d_%0d got %0d required %0d", k, got_digit(k), ref_digit(8388607, k));
            end
        end
        step();
    endtask

    task automatic test_ignore_start();
        int lat, bc, extra;
        start_conv(1234567);
        for (int i = 0; i < 4; i++) step();
        bus.start = 1'b1;
        bus.value_C2 = 23'd4321;
        step();
        bus.start = 1'b0;
        wait_done(lat, bc);
        checks++;
        if (lat + 5 !== 23) begin
            errors++;
            $display("FAIL ignore_latency got %0d required 23", lat + 5);
        end
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (got_digit(k) !== ref_digit(1234567, k)) begin
                errors++;
                $display("FAIL ignore_digit d_%0d got %0d required %0d", k, got_digit(k), ref_digit(1234567, k));
            end
        end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL ignore_extra_done got %0d pulses required 0", extra);
        end
    endtask

    task automatic test_abort();
        int lat, bc, extra;
        start_conv(999999);
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_ctrl busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (got_digit(k) !== 0) begin
                errors++;
                $display("FAIL abort_digit d_%0d got %0d required 0", k, got_digit(k));
            end
        end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL abort_done got %0d pulses required 0", extra);
        end
        start_conv(42);
        wait_done(lat, bc);
        checks++;
        if (lat !== 23) begin
            errors++;
            $display("FAIL abort_restart_latency got %0d required 23", lat);
        end
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (got_digit(k) !== ref_digit(42, k)) begin
                errors++;
                $display("FAIL abort_restart d_%0d got %0d required %0d", k, got_digit(k), ref_digit(42, k));
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, bc;
        start_conv(5);
        wait_done(lat1, bc);
        checks++;
        if (lat1 !== 23 || got_digit(1) !== 5) begin
            errors++;
            $display("FAIL b2b_first lat %0d d_1 %0d required 23 5", lat1, got_digit(1));
        end
        start_conv(9999);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept busy=%b required 1", bus.busy);
        end
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (got_digit(1) !== 5 || got_digit(4) !== 0) begin
            errors++;
            $display("FAIL b2b_hold d_1 %0d d_4 %0d required 5 0", got_digit(1), got_digit(4));
        end
        wait_done(lat2, bc);
        checks++;
        if (lat1 + 1 + 10 + lat2 !== 47) begin
            errors++;
            $display("FAIL b2b_second_latency got %0d required 47", lat1 + 1 + 10 + lat2);
        end
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (got_digit(k) !== ref_digit(9999, k)) begin
                errors++;
                $display("FAIL b2b_digit d_%0d got %0d required %0d", k, got_digit(k), ref_digit(9999, k));
            end
        end
        step();
    endtask

    task automatic test_random();
        int v, lat, bc, n;
        int fixed_vals[8] = '{1, 9, 10, 99, 100, 999999, 1000000, 8000000};
        n = 0;
        for (int t = 0; t < 48; t++) begin
            v = (t < 8) ? fixed_vals[t] : int'($urandom_range(8388607, 0));
            start_conv(v);
            wait_done(lat, bc);
            checks++;
            if (lat !== 23) begin
                errors++;
                $display("FAIL rand_latency value %0d got %0d required 23", v, lat);
            end
            for (int k = 1; k <= 7; k++) begin
                checks++;
                if (got_digit(k) !== ref_digit(v, k) || got_digit(k) > 9) begin
                    errors++;
                    $display("FAIL rand_digit value %0d d_%0d got %0d required %0d", v, k, got_digit(k), ref_digit(v, k));
                end
            end
            checks++;
            if (got_digit(7) > 8) begin
                errors++;
                $display("FAIL rand_d7_range value %0d d_7 %0d required <= 8", v, got_digit(7));
            end
            n++;
            if (n % 3 == 0) step();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.value_C2 = '0;
        test_reset();
        test_zero();
        test_max();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
